// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the pipeline-stage register: occupancy states,
// default field widths and the EX/MEM control-bit layout.
package pipe_pkg;

  localparam int DEF_CTRL_W = 9;
  localparam int DEF_DATA_W = 101;

  // Control-field bit offsets; two-bit fields give their least significant bit.
  localparam int CTRL_MEMTOREG = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_BRANCH   = 6;
  localparam int CTRL_ZERO     = 7;
  localparam int CTRL_JUMP     = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

  function automatic logic [DEF_CTRL_W-1:0] ctrl_pack(
    input logic       memToReg,
    input logic       regWrite,
    input logic [1:0] memWrite,
    input logic [1:0] memRead,
    input logic       branch,
    input logic       zero,
    input logic       jump
  );
    logic [DEF_CTRL_W-1:0] c;
    c = '0;
    c[CTRL_MEMTOREG]        = memToReg;
    c[CTRL_REGWRITE]        = regWrite;
    c[CTRL_MEMWRITE +: 2]   = memWrite;
    c[CTRL_MEMREAD +: 2]    = memRead;
    c[CTRL_BRANCH]          = branch;
    c[CTRL_ZERO]            = zero;
    c[CTRL_JUMP]            = jump;
    return c;
  endfunction

  // True when a control word would write architectural state downstream.
  function automatic logic ctrl_has_side_effect(input logic [DEF_CTRL_W-1:0] c);
    return c[CTRL_REGWRITE] | (|c[CTRL_MEMWRITE +: 2]);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of a pipeline-stage register.
// master = the surrounding pipeline, slave = the stage itself.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              In_valid;
  logic              In_ready;
  logic [CTRL_W-1:0] In_ctrl;
  logic [DATA_W-1:0] In_data;
  logic              Flush;
  logic              Out_valid;
  logic              Out_ready;
  logic [CTRL_W-1:0] Out_ctrl;
  logic [DATA_W-1:0] Out_data;

  modport master (
    output In_valid, In_ctrl, In_data, Flush, Out_ready,
    input  In_ready, Out_valid, Out_ctrl, Out_data
  );

  modport slave (
    input  In_valid, In_ctrl, In_data, Flush, Out_ready,
    output In_ready, Out_valid, Out_ctrl, Out_data
  );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One storage entry of the stage: valid bit plus control and data fields.
// Clear wins over load; clear only drops valid so the data field keeps its value.
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready flow control, flush and bubble gating.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid build with a registered In_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  pipe_stage_reg_if.slave  bus
);

  logic              inReady;
  logic              accept;
  logic              consume;
  logic              mainLoad;
  logic              mainClear;
  logic [CTRL_W-1:0] mainCtrlIn;
  logic [DATA_W-1:0] mainDataIn;
  logic              mainValid;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainData;

  assign accept  = bus.In_valid && inReady;
  assign consume = mainValid && bus.Out_ready;

  pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .load_i  (mainLoad),
    .clear_i (mainClear),
    .ctrl_i  (mainCtrlIn),
    .data_i  (mainDataIn),
    .valid_o (mainValid),
    .ctrl_o  (mainCtrl),
    .data_o  (mainData)
  );

`ifdef PIPE_STAGE_SKID_EN
  occ_state_e        state_q, state_d;
  logic              skidLoad;
  logic              skidClear;
  logic              skidValid;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;

  pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .load_i  (skidLoad),
    .clear_i (skidClear),
    .ctrl_i  (bus.In_ctrl),
    .data_i  (bus.In_data),
    .valid_o (skidValid),
    .ctrl_o  (skidCtrl),
    .data_o  (skidData)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (consume && !accept)      state_d = ST_EMPTY;
          else if (!consume && accept) state_d = ST_TWO;
        end
        ST_TWO:   if (consume) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // In ONE a beat that cannot go to main (main still stalled) lands in skid;
  // in TWO a consume refills main from skid so arrival order is preserved.
  always_comb begin
    mainLoad   = 1'b0;
    mainClear  = 1'b0;
    mainCtrlIn = bus.In_ctrl;
    mainDataIn = bus.In_data;
    skidLoad   = 1'b0;
    skidClear  = 1'b0;
    if (bus.Flush) begin
      mainClear = 1'b1;
      skidClear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: mainLoad = accept;
        ST_ONE: begin
          if (consume) begin
            mainLoad  = accept;
            mainClear = !accept;
          end else begin
            skidLoad = accept;
          end
        end
        ST_TWO: begin
          if (consume && skidValid) begin
            mainLoad   = 1'b1;
            mainCtrlIn = skidCtrl;
            mainDataIn = skidData;
            skidClear  = 1'b1;
          end
        end
        default: begin
          mainClear = 1'b1;
          skidClear = 1'b1;
        end
      endcase
    end
  end

  assign inReady = (state_q != ST_TWO);
`else
  assign inReady = !mainValid || bus.Out_ready;

  always_comb begin
    mainLoad   = accept;
    mainClear  = bus.Flush || (consume && !accept);
    mainCtrlIn = bus.In_ctrl;
    mainDataIn = bus.In_data;
  end
`endif

  // Bubble gating keeps an empty stage from asserting any control bit downstream.
  assign bus.In_ready  = inReady;
  assign bus.Out_valid = mainValid;
  assign bus.Out_ctrl  = mainValid ? mainCtrl : '0;
  assign bus.Out_data  = mainData;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: table-driven vectors, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = DEF_CTRL_W;
  localparam int DW = DEF_DATA_W;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          f;
    logic          r;
    logic          eV;
    logic [CW-1:0] eC;
    logic [DW-1:0] eD;
    logic          eR;
  } vec_t;

  beat_t         q[$];
  logic [DW-1:0] lastData;
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                               input logic f, input logic r);
    @(negedge Clk);
    bus.In_valid  = v;
    bus.In_ctrl   = c;
    bus.In_data   = d;
    bus.Flush     = f;
    bus.Out_ready = r;
    #1;
  endtask

  function automatic logic modelReady();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || bus.Out_ready;
  endfunction

  task automatic checkModel();
    logic expValid;
    expValid = q.size() > 0;
    checkOutput("out_valid", bus.Out_valid, expValid);
    checkOutput("out_ctrl",  bus.Out_ctrl,  expValid ? q[0].ctrl : '0);
    checkOutput("out_data",  bus.Out_data,  expValid ? q[0].data : lastData);
    checkOutput("in_ready",  bus.In_ready,  modelReady());
  endtask

  // Applies the rising edge that follows the currently driven inputs.
  task automatic modelStep();
    logic acc, cons;
    beat_t b;
    if (bus.Flush) begin
      if (q.size() > 0) lastData = q[0].data;
      q.delete();
    end else begin
      acc  = bus.In_valid && modelReady();
      cons = (q.size() > 0) && bus.Out_ready;
      if (cons) begin
        lastData = q[0].data;
        void'(q.pop_front());
      end
      if (acc) begin
        b.ctrl = bus.In_ctrl;
        b.data = bus.In_data;
        q.push_back(b);
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic f, input logic r);
    applyStimulus(v, c, d, f, r);
    checkModel();
    modelStep();
  endtask

  vec_t          tbl[10];
  logic [DW-1:0] stallData[3];
  logic [DW-1:0] seen[$];
  logic [CW-1:0] rw;
  logic [127:0]  rnd;

  initial begin
    logic [CW-1:0] c1, c2, c3, c4;
    int offerIdx;
    c1 = ctrl_pack(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    c2 = ctrl_pack(1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    c3 = 9'h1FF;
    c4 = ctrl_pack(1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1);
    rw = ctrl_pack(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Streaming 1..4 then bubbles with all control bits high on the input.
    tbl[0] = '{1'b1, c1,   'd1,    1'b0, 1'b1, 1'b0, '0, 'd0, 1'b1};
    tbl[1] = '{1'b1, c2,   'd2,    1'b0, 1'b1, 1'b1, c1, 'd1, 1'b1};
    tbl[2] = '{1'b1, c3,   'd3,    1'b0, 1'b1, 1'b1, c2, 'd2, 1'b1};
    tbl[3] = '{1'b1, c4,   'd4,    1'b0, 1'b1, 1'b1, c3, 'd3, 1'b1};
    tbl[4] = '{1'b0, c3,   'h77,   1'b0, 1'b1, 1'b1, c4, 'd4, 1'b1};
    for (int i = 5; i < 10; i++)
      tbl[i] = '{1'b0, c3, 'h77, 1'b0, 1'b1, 1'b0, '0, 'd4, 1'b1};
    stallData[0] = 'hA;
    stallData[1] = 'hB;
    stallData[2] = 'hC;

    lastData      = '0;
    Rst_n         = 1'b0;
    bus.In_valid  = 1'b0;
    bus.In_ctrl   = '0;
    bus.In_data   = '0;
    bus.Flush     = 1'b0;
    bus.Out_ready = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    checkOutput("rst_valid", bus.Out_valid, 1'b0);
    checkOutput("rst_ctrl",  bus.Out_ctrl,  '0);
    checkOutput("rst_data",  bus.Out_data,  '0);
    checkOutput("rst_ready", bus.In_ready,  1'b1);
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].f, tbl[i].r);
      checkOutput($sformatf("tbl%0d_valid", i), bus.Out_valid, tbl[i].eV);
      checkOutput($sformatf("tbl%0d_ctrl", i),  bus.Out_ctrl,  tbl[i].eC);
      checkOutput($sformatf("tbl%0d_data", i),  bus.Out_data,  tbl[i].eD);
      checkOutput($sformatf("tbl%0d_ready", i), bus.In_ready,  tbl[i].eR);
      checkModel();
      modelStep();
    end

    // Stall: only CAP beats get in, then everything drains in order.
    offerIdx = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, rw, stallData[offerIdx], 1'b0, 1'b0);
      if (i == 3) begin
        checkOutput("stall_ready", bus.In_ready, 1'b0);
        checkOutput("stall_head",  bus.Out_data, 'hA);
      end
      checkModel();
      if (modelReady()) offerIdx++;
      modelStep();
    end
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      if (offerIdx < 3) applyStimulus(1'b1, rw, stallData[offerIdx], 1'b0, 1'b1);
      else              applyStimulus(1'b0, rw, 'h0, 1'b0, 1'b1);
      if (bus.Out_valid) seen.push_back(bus.Out_data);
      checkModel();
      if (offerIdx < 3 && modelReady()) offerIdx++;
      modelStep();
    end
    checkOutput("drain_count", seen.size(), 3);
    for (int i = 0; i < 3 && i < seen.size(); i++)
      checkOutput($sformatf("drain%0d", i), seen[i], stallData[i]);

    // Flush with held RegWrite beats and an incoming beat present.
    cycle(1'b1, rw, 'h11, 1'b0, 1'b0);
    cycle(1'b1, rw, 'h22, 1'b0, 1'b0);
    cycle(1'b1, rw, 'hDEAD, 1'b1, 1'b0);
    applyStimulus(1'b0, rw, 'h0, 1'b0, 1'b1);
    checkOutput("flush_valid", bus.Out_valid, 1'b0);
    checkOutput("flush_ctrl",  bus.Out_ctrl,  '0);
    checkOutput("flush_side",  ctrl_has_side_effect(bus.Out_ctrl), 1'b0);
    checkModel();
    modelStep();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, rw, 'h0, 1'b0, 1'b1);
      checkOutput("flush_gone", bus.Out_valid, 1'b0);
      checkModel();
      modelStep();
    end
    // Flush beats an accept even when the stage is empty and ready.
    cycle(1'b1, rw, 'hBEEF, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 'h0, 1'b0, 1'b1);
    checkOutput("flush_empty", bus.Out_valid, 1'b0);
    checkModel();
    modelStep();

    // Full stage: raising Out_ready reaches In_ready at once only without skid.
    cycle(1'b1, c1, 'h55, 1'b0, 1'b0);
    cycle(1'b1, c2, 'h66, 1'b0, 1'b0);
    applyStimulus(1'b1, c4, 'h77, 1'b0, 1'b0);
    checkOutput("full_ready", bus.In_ready, 1'b0);
    checkModel();
    bus.Out_ready = 1'b1;
    #1;
    checkOutput("raise_ready", bus.In_ready, (CAP == 1) ? 1'b1 : 1'b0);
    modelStep();
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 'h0, 1'b0, 1'b1);

    // Asynchronous reset while a beat with all control bits set is held.
    cycle(1'b1, 9'h1FF, 'h99, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 'h0, 1'b0, 1'b0);
    checkModel();
    #1;
    Rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", bus.Out_valid, 1'b0);
    checkOutput("arst_ctrl",  bus.Out_ctrl,  '0);
    checkOutput("arst_data",  bus.Out_data,  '0);
    checkOutput("arst_ready", bus.In_ready,  1'b1);
    q.delete();
    lastData = '0;
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cycle(($urandom % 4) != 0, CW'($urandom), rnd[DW-1:0],
            ($urandom % 20) == 0, ($urandom % 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
